// File: rtl/skein512_ubi_core.sv
// Folded Threefish-512 / UBI compression engine, GROUPS 4-round groups per clock.
// Optional multi-block chaining (in_chain/in_first, internal position) under `SKEIN_UBI_CHAIN_EN.
module skein512_ubi_core #(
  parameter int unsigned GROUPS  = 1,
  parameter int unsigned OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_key,
  input  logic [511:0] in_msg,
  input  logic [63:0]  in_t0,
  input  logic [63:0]  in_t1,
`ifdef SKEIN_UBI_CHAIN_EN
  input  logic         in_chain,
  input  logic         in_first,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_hash
);

  localparam int unsigned SW   = 5;
  localparam int unsigned NSUB = 18;
  localparam logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;
  localparam int unsigned ROT [8][4] = '{
    '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44,  9, 54, 56},
    '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{ 8, 35, 56, 22}
  };

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;
  typedef logic [0:7][63:0] blk_t;
  typedef logic [0:8][63:0] ks_t;
  typedef logic [0:2][63:0] tw_t;

  if (!(GROUPS == 1 || GROUPS == 2 || GROUPS == 3 || GROUPS == 6 || GROUPS == 9 || GROUPS == 18))
  begin : g_bad_groups
    $fatal(1, "skein512_ubi_core: GROUPS must be one of 1, 2, 3, 6, 9, 18");
  end

  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // Small-range modulo helpers; arguments never exceed 25.
  function automatic logic [3:0] mod9(input logic [SW-1:0] x);
    logic [SW-1:0] y;
    y = x;
    if (y >= SW'(18))     y = y - SW'(18);
    else if (y >= SW'(9)) y = y - SW'(9);
    return 4'(y);
  endfunction

  function automatic logic [1:0] mod3(input logic [SW-1:0] x);
    logic [SW-1:0] y;
    y = x;
    for (int n = 0; n < 7; n++) begin
      if (y >= SW'(3)) y = y - SW'(3);
    end
    return 2'(y);
  endfunction

  function automatic blk_t add_subkey(input blk_t v, input ks_t k, input tw_t t,
                                      input logic [SW-1:0] g);
    blk_t r;
    for (int i = 0; i < 8; i++) r[i] = v[i] + k[mod9(g + SW'(i))];
    r[5] = r[5] + t[mod3(g)];
    r[6] = r[6] + t[mod3(g + SW'(1))];
    r[7] = r[7] + 64'(g);
    return r;
  endfunction

  // One MIX layer plus word permutation; odd groups use the second half of the rotation table.
  function automatic blk_t mix_round(input blk_t v, input logic odd, input int unsigned rr);
    blk_t f;
    blk_t r;
    for (int j = 0; j < 4; j++) begin
      f[2*j]   = v[2*j] + v[2*j+1];
      f[2*j+1] = (odd ? rotl(v[2*j+1], ROT[rr+4][j]) : rotl(v[2*j+1], ROT[rr][j])) ^ f[2*j];
    end
    r[0] = f[2]; r[1] = f[1]; r[2] = f[4]; r[3] = f[7];
    r[4] = f[6]; r[5] = f[5]; r[6] = f[0]; r[7] = f[3];
    return r;
  endfunction

  function automatic blk_t do_group(input blk_t v, input ks_t k, input tw_t t,
                                    input logic [SW-1:0] g);
    blk_t r;
    r = add_subkey(v, k, t, g);
    for (int unsigned rr = 0; rr < 4; rr++) r = mix_round(r, g[0], rr);
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  blk_t            v_q, v_d;
  blk_t            msg_q, msg_d;
  ks_t             k_q, k_d;
  tw_t             t_q, t_d;
  blk_t            run_v_c;
  blk_t            fin_c;
  logic            done_c;
`ifdef SKEIN_UBI_CHAIN_EN
  logic [63:0]     pos_q, pos_d;
  logic            unused_c;
  assign unused_c = ^{in_t0, in_t1[62]};
`endif

  // Datapath: GROUPS groups from s, plus final subkey and feed-forward for the last cycle.
  always_comb begin : p_rounds
    blk_t x;
    x = v_q;
    for (int unsigned j = 0; j < GROUPS; j++) x = do_group(x, k_q, t_q, s_q + SW'(j));
    run_v_c = x;
    fin_c   = add_subkey(x, k_q, t_q, SW'(NSUB)) ^ msg_q;
  end

  always_comb begin : p_fsm
    blk_t        key_w;
    logic [63:0] t0_w;
    logic [63:0] t1_w;
    state_d = state_q;
    s_d     = s_q;
    v_d     = v_q;
    msg_d   = msg_q;
    k_d     = k_q;
    t_d     = t_q;
    done_c  = 1'b0;
    key_w   = in_key;
    t0_w    = in_t0;
    t1_w    = in_t1;
`ifdef SKEIN_UBI_CHAIN_EN
    pos_d   = pos_q;
    if (in_chain) key_w = out_hash;
    t0_w    = (in_first ? 64'd0 : pos_q) + 64'd64;
    t1_w    = {in_t1[63], in_first, in_t1[61:0]};
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          k_d[8] = KS_PARITY;
          for (int i = 0; i < 8; i++) begin
            k_d[i] = key_w[i];
            k_d[8] = k_d[8] ^ key_w[i];
          end
          t_d     = {t0_w, t1_w, t0_w ^ t1_w};
          msg_d   = in_msg;
          v_d     = in_msg;
          s_d     = '0;
          state_d = ST_RUN;
`ifdef SKEIN_UBI_CHAIN_EN
          pos_d   = t0_w;
`endif
        end
      end
      ST_RUN: begin
        s_d = s_q + SW'(GROUPS);
        v_d = run_v_c;
        if (s_d == SW'(NSUB)) begin
          v_d     = fin_c;
          s_d     = '0;
          done_c  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      v_q     <= '0;
      msg_q   <= '0;
      k_q     <= '0;
      t_q     <= '0;
`ifdef SKEIN_UBI_CHAIN_EN
      pos_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      v_q     <= v_d;
      msg_q   <= msg_d;
      k_q     <= k_d;
      t_q     <= t_d;
`ifdef SKEIN_UBI_CHAIN_EN
      pos_q   <= pos_d;
`endif
    end
  end

  assign in_ready = (state_q == ST_IDLE);

  if (OUT_REG != 0) begin : g_out_reg
    logic [511:0] out_hash_q, out_hash_d;
    logic         out_valid_q, out_valid_d;

    always_comb begin : p_out
      out_hash_d  = out_hash_q;
      out_valid_d = out_valid_q;
      if (done_c) begin
        out_hash_d  = fin_c;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_out_regs
      if (!rst_n) begin
        out_hash_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_hash_q  <= out_hash_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign out_hash  = out_hash_q;
    assign out_valid = out_valid_q;
  end else begin : g_out_direct
    // The state register holds the finished result throughout HOLD and the following IDLE.
    assign out_hash  = v_q;
    assign out_valid = (state_q == ST_HOLD);
  end

endmodule

// File: tb/tb_skein512_ubi_core.sv
// Directed bench for skein512_ubi_core: three instances (GROUPS 1/3/18) against a round-level model.
module tb_skein512_ubi_core;

  localparam int GRP [3] = '{1, 3, 18};
  localparam int RT [8][4] = '{
    '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44,  9, 54, 56},
    '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{ 8, 35, 56, 22}
  };
  localparam int PI [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
  // Published all-zero Threefish-512 ciphertext, written as a byte stream.
  localparam logic [511:0] KAT_BYTES =
    512'hB1A2BBC6EF6025BC40EB3822161F36E375D1BB0AEE3186FBD19E47C5D479947B7BC2F8586E35F0CFF7E7F03084B0B7B1F1AB3961A580A3E97EB41EA14A6D7BBE;

  logic         clk;
  logic         rst_n;
  logic [511:0] in_key;
  logic [511:0] in_msg;
  logic [63:0]  in_t0;
  logic [63:0]  in_t1;
  logic         in_valid    [3];
  logic         out_ready   [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [511:0] out_hash_w  [3];
`ifdef SKEIN_UBI_CHAIN_EN
  logic         in_chain;
  logic         in_first;
  logic [63:0]  pos_m    [3];
  logic [511:0] last_res [3];
`endif

  int n_chk;
  int n_bad;

  skein512_ubi_core #(.GROUPS(1), .OUT_REG(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_key(in_key), .in_msg(in_msg), .in_t0(in_t0), .in_t1(in_t1),
`ifdef SKEIN_UBI_CHAIN_EN
    .in_chain(in_chain), .in_first(in_first),
`endif
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .out_hash(out_hash_w[0])
  );

  skein512_ubi_core #(.GROUPS(3), .OUT_REG(0)) u_g3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_key(in_key), .in_msg(in_msg), .in_t0(in_t0), .in_t1(in_t1),
`ifdef SKEIN_UBI_CHAIN_EN
    .in_chain(in_chain), .in_first(in_first),
`endif
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .out_hash(out_hash_w[1])
  );

  skein512_ubi_core #(.GROUPS(18), .OUT_REG(1)) u_g18 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_key(in_key), .in_msg(in_msg), .in_t0(in_t0), .in_t1(in_t1),
`ifdef SKEIN_UBI_CHAIN_EN
    .in_chain(in_chain), .in_first(in_first),
`endif
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .out_hash(out_hash_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // Threefish-512 round by round (subkey every fourth round), then UBI feed-forward.
  function automatic logic [511:0] ubi_model(input logic [511:0] key, input logic [511:0] msg,
                                             input logic [63:0] t0, input logic [63:0] t1);
    logic [63:0]  k [9];
    logic [63:0]  t [3];
    logic [63:0]  v [8];
    logic [63:0]  f [8];
    logic [511:0] r;
    k[8] = 64'h1BD11BDAA9FC1A22;
    for (int i = 0; i < 8; i++) begin
      k[i] = key[511-64*i -: 64];
      k[8] = k[8] ^ k[i];
      v[i] = msg[511-64*i -: 64];
    end
    t[0] = t0; t[1] = t1; t[2] = t0 ^ t1;
    for (int d = 0; d <= 72; d++) begin
      if (d % 4 == 0) begin
        int sk;
        sk = d / 4;
        for (int i = 0; i < 8; i++) v[i] = v[i] + k[(sk + i) % 9];
        v[5] = v[5] + t[sk % 3];
        v[6] = v[6] + t[(sk + 1) % 3];
        v[7] = v[7] + 64'(sk);
      end
      if (d < 72) begin
        for (int j = 0; j < 4; j++) begin
          f[2*j]   = v[2*j] + v[2*j+1];
          f[2*j+1] = rl(v[2*j+1], RT[d % 8][j]) ^ f[2*j];
        end
        for (int i = 0; i < 8; i++) v[i] = f[PI[i]];
      end
    end
    for (int i = 0; i < 8; i++) r[511-64*i -: 64] = v[i] ^ msg[511-64*i -: 64];
    return r;
  endfunction

  function automatic logic [511:0] le_words(input logic [511:0] b);
    logic [511:0] r;
    logic [63:0]  w;
    logic [63:0]  rw;
    for (int i = 0; i < 8; i++) begin
      w = b[511-64*i -: 64];
      for (int by = 0; by < 8; by++) rw[63-8*by -: 8] = w[8*by +: 8];
      r[511-64*i -: 64] = rw;
    end
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  // Expected result for the block being accepted now, from the current input bus.
  task automatic bookkeep(input int d, output logic [511:0] exp);
    logic [511:0] ke;
    logic [63:0]  t0e;
    logic [63:0]  t1e;
    ke = in_key; t0e = in_t0; t1e = in_t1;
`ifdef SKEIN_UBI_CHAIN_EN
    pos_m[d] = (in_first ? 64'd0 : pos_m[d]) + 64'd64;
    t0e = pos_m[d];
    t1e = {in_t1[63], in_first, in_t1[61:0]};
    if (in_chain) ke = last_res[d];
`endif
    exp = ubi_model(ke, in_msg, t0e, t1e);
`ifdef SKEIN_UBI_CHAIN_EN
    last_res[d] = exp;
`endif
  endtask

  task automatic clear_models();
`ifdef SKEIN_UBI_CHAIN_EN
    for (int d = 0; d < 3; d++) begin
      pos_m[d] = '0;
      last_res[d] = '0;
    end
`endif
  endtask

  // Offer the current bus to instance d; returns one step after the accepting edge.
  task automatic offer(input int d, output logic [511:0] exp);
    int n;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready_w[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("g%0d_accept_wait", GRP[d]), 512'(n < 50), 512'(1));
    bookkeep(d, exp);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input logic [511:0] exp, input string tag);
    int lat;
    int hi;
    lat = 1;
    hi = 0;
    while (!out_valid_w[d] && lat < 40) begin
      if (in_ready_w[d]) hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready_w[d]) hi++;
    chk({tag, "_lat"}, 512'(lat), 512'(18 / GRP[d] + 1));
    chk({tag, "_rdy_low"}, 512'(hi), 512'(0));
    chk({tag, "_hash"}, out_hash_w[d], exp);
  endtask

  task automatic consume(input int d, input string tag);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({tag, "_vld_fall"}, 512'(out_valid_w[d]), 512'(0));
    chk({tag, "_rdy_back"}, 512'(in_ready_w[d]), 512'(1));
  endtask

  initial begin : main
    logic [511:0] e;
    logic [511:0] ea;
    logic [511:0] eb;
    int           bad;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_key = '0; in_msg = '0; in_t0 = '0; in_t1 = '0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
`ifdef SKEIN_UBI_CHAIN_EN
    in_chain = 1'b0;
    in_first = 1'b0;
`endif
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("g%0d_rst_in_ready", GRP[d]), 512'(in_ready_w[d]), 512'(1));
      chk($sformatf("g%0d_rst_out_valid", GRP[d]), 512'(out_valid_w[d]), 512'(0));
      chk($sformatf("g%0d_rst_out_hash", GRP[d]), out_hash_w[d], '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero block on every folding factor.
    for (int d = 0; d < 3; d++) begin
      in_key = '0; in_msg = '0; in_t0 = '0; in_t1 = '0;
      offer(d, e);
`ifndef SKEIN_UBI_CHAIN_EN
      e = le_words(KAT_BYTES);
`endif
      wait_done(d, e, $sformatf("g%0d_zero", GRP[d]));
      consume(d, $sformatf("g%0d_zero", GRP[d]));
    end

    // Random blocks.
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < 5; b++) begin
        in_key = rnd512(); in_msg = rnd512();
        in_t0 = {32'($urandom), 32'($urandom)};
        in_t1 = {32'($urandom), 32'($urandom)};
        offer(d, e);
        wait_done(d, e, $sformatf("g%0d_rnd%0d", GRP[d], b));
        consume(d, $sformatf("g%0d_rnd%0d", GRP[d], b));
      end
    end

    // Backpressure with ignored in_valid pulses, then simultaneous out_ready and in_valid.
    in_key = rnd512(); in_msg = rnd512(); in_t0 = 64'd5; in_t1 = 64'h7000_0000_0000_0001;
    offer(0, ea);
    wait_done(0, ea, "bp_a");
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid[0] = (c % 2 == 0);
      in_key = rnd512(); in_msg = rnd512();
      @(posedge clk); #1;
      if (out_valid_w[0] !== 1'b1 || out_hash_w[0] !== ea || in_ready_w[0] !== 1'b0) bad++;
    end
    chk("bp_hold_stable", 512'(bad), 512'(0));
    in_key = rnd512(); in_msg = rnd512(); in_t0 = 64'h40; in_t1 = 64'h3000_0000_0000_0000;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("bp_vld_fall", 512'(out_valid_w[0]), 512'(0));
    chk("bp_idle_ready", 512'(in_ready_w[0]), 512'(1));
    bookkeep(0, eb);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_b_accepted", 512'(in_ready_w[0]), 512'(0));
    wait_done(0, eb, "bp_b");
    consume(0, "bp_b");

    // Reset pulse in the middle of a block (s=8).
    in_key = rnd512(); in_msg = rnd512(); in_t0 = 64'd9; in_t1 = 64'd3;
    offer(0, e);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 512'(out_valid_w[0]), 512'(0));
    chk("rst_mid_in_ready", 512'(in_ready_w[0]), 512'(1));
    chk("rst_mid_out_hash", out_hash_w[0], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_models();
    @(posedge clk); #1;
    in_key = rnd512(); in_msg = rnd512(); in_t0 = 64'd17; in_t1 = 64'h0123_4567_89AB_CDEF;
    offer(0, e);
    wait_done(0, e, "post_rst");
    consume(0, "post_rst");

`ifdef SKEIN_UBI_CHAIN_EN
    // Three chained blocks: positions 64/128/192, key taken from the previous result.
    begin : chain_test
      logic [511:0] k0;
      logic [511:0] m [3];
      logic [511:0] ec [3];
      logic [63:0]  t1b;
      t1b = 64'h3000_0000_0000_0000;
      k0 = rnd512();
      for (int i = 0; i < 3; i++) m[i] = rnd512();
      ec[0] = ubi_model(k0, m[0], 64'd64, t1b | 64'h4000_0000_0000_0000);
      ec[1] = ubi_model(ec[0], m[1], 64'd128, t1b);
      ec[2] = ubi_model(ec[1], m[2], 64'd192, t1b | 64'h8000_0000_0000_0000);
      for (int i = 0; i < 3; i++) begin
        in_key   = (i == 0) ? k0 : rnd512();
        in_msg   = m[i];
        in_t0    = {32'($urandom), 32'($urandom)};
        in_t1    = (i == 2) ? (t1b | 64'h8000_0000_0000_0000) : t1b;
        in_first = (i == 0);
        in_chain = (i != 0);
        offer(0, e);
        in_chain = 1'b0;
        in_first = 1'b0;
        wait_done(0, ec[i], $sformatf("chain%0d", i));
        consume(0, $sformatf("chain%0d", i));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
